// File: rtl/lfsr_prng.sv
// lfsr_prng: parametrised LFSR pseudo-random word generator.
// Runtime Fibonacci/Galois selection, seed load, zero lock-up recovery to SEED,
// and a valid/ready output stream that holds the word until it is accepted.
// Optional feature macro LFSR_PERIOD_CNT_EN adds period_cnt/period_wrap, which
// count advances since the last reset/load and flag a return to the loaded seed.
module lfsr_prng #(
    parameter int unsigned WIDTH = 32,
    parameter logic [63:0] TAPS  = 64'h0000_0000_8020_0003,
    parameter logic [63:0] SEED  = 64'd1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             mode,
    input  logic             load,
    input  logic [WIDTH-1:0] seed_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] q,
    output logic             lock_err
`ifdef LFSR_PERIOD_CNT_EN
    ,
    output logic [WIDTH-1:0] period_cnt,
    output logic             period_wrap
`endif
);

    // Tap mask and seed are carried in 64-bit containers and cut to WIDTH here.
    localparam logic [WIDTH-1:0] TAPS_W = TAPS[WIDTH-1:0];
    localparam logic [WIDTH-1:0] SEED_W = SEED[WIDTH-1:0];

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    if (WIDTH < 4 || WIDTH > 64) begin : g_bad_width
        $error("lfsr_prng: WIDTH must be within 4..64");
    end
    if (SEED_W == '0) begin : g_bad_seed
        $error("lfsr_prng: SEED must be nonzero (an all-zero LFSR never leaves zero)");
    end

    logic [0:0]       fsm_q, fsm_d;
    logic [WIDTH-1:0] lfsr_q, lfsr_d;
    logic             lock_err_q, lock_err_d;

    logic             accept;
    logic             fb;
    logic [WIDTH-1:0] tap_bits;
    logic [WIDTH-1:0] fib_next;
    logic [WIDTH-1:0] gal_next;
    logic [WIDTH-1:0] cand;
    logic             update;

    // Per-bit tap gating; the Fibonacci feedback is the XOR of these terms.
    genvar gi;
    for (gi = 0; gi < WIDTH; gi++) begin : g_taps
        assign tap_bits[gi] = TAPS_W[gi] & lfsr_q[gi];
    end
    assign fb = ^tap_bits;

    assign out_valid = (fsm_q == ST_RUN);
    assign q         = lfsr_q;
    assign lock_err  = lock_err_q;
    assign accept    = out_valid & out_ready;

    // Next state: load beats advance; any zero result is replaced by SEED.
    always_comb begin
        fib_next   = {fb, lfsr_q[WIDTH-1:1]};
        gal_next   = (lfsr_q >> 1) ^ ({WIDTH{lfsr_q[0]}} & TAPS_W);
        cand       = lfsr_q;
        update     = 1'b0;
        if (load) begin
            cand   = seed_in;
            update = 1'b1;
        end else if (accept) begin
            cand   = mode ? gal_next : fib_next;
            update = 1'b1;
        end
        lfsr_d     = cand;
        lock_err_d = 1'b0;
        if (update && cand == '0) begin
            lfsr_d     = SEED_W;
            lock_err_d = 1'b1;
        end
    end

    // Stream FSM: IDLE waits for en; RUN holds the word until it is taken,
    // and drops back to IDLE only on an accept seen with en low.
    always_comb begin
        fsm_d = fsm_q;
        case (fsm_q)
            ST_IDLE: if (en) fsm_d = ST_RUN;
            ST_RUN:  if (accept && !en) fsm_d = ST_IDLE;
            default: fsm_d = ST_IDLE;
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q      <= ST_IDLE;
            lfsr_q     <= SEED_W;
            lock_err_q <= 1'b0;
        end else begin
            fsm_q      <= fsm_d;
            lfsr_q     <= lfsr_d;
            lock_err_q <= lock_err_d;
        end
    end

`ifdef LFSR_PERIOD_CNT_EN
    logic [WIDTH-1:0] period_cnt_q, period_cnt_d;
    logic [WIDTH-1:0] ref_seed_q, ref_seed_d;
    logic             period_wrap_q, period_wrap_d;

    assign period_cnt  = period_cnt_q;
    assign period_wrap = period_wrap_q;

    // Advance counter; restarts on load, recovery, or return to the reference seed.
    always_comb begin
        period_cnt_d  = period_cnt_q;
        ref_seed_d    = ref_seed_q;
        period_wrap_d = 1'b0;
        if (load) begin
            period_cnt_d = '0;
            ref_seed_d   = lfsr_d;
        end else if (accept) begin
            if (lock_err_d) begin
                period_cnt_d = '0;
            end else if (lfsr_d == ref_seed_q) begin
                period_cnt_d  = '0;
                period_wrap_d = 1'b1;
            end else begin
                period_cnt_d = period_cnt_q + 1'b1;
            end
        end
    end

    // Counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            period_cnt_q  <= '0;
            ref_seed_q    <= SEED_W;
            period_wrap_q <= 1'b0;
        end else begin
            period_cnt_q  <= period_cnt_d;
            ref_seed_q    <= ref_seed_d;
            period_wrap_q <= period_wrap_d;
        end
    end
`endif

endmodule

// File: tb/tb_lfsr_prng.sv
// tb_lfsr_prng: directed bench for lfsr_prng. Instance A uses the 32-bit
// defaults; instance B is WIDTH=4, TAPS=4'b0011, SEED=1 for the full-period walk.
// Period counter checks are active when LFSR_PERIOD_CNT_EN is defined.
module tb_lfsr_prng;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Instance A (defaults)
    logic        rst_a, en_a, mode_a, load_a, ready_a;
    logic [31:0] seed_a, q_a;
    logic        valid_a, lerr_a;
    // Instance B (4-bit)
    logic        rst_b, en_b, mode_b, load_b, ready_b;
    logic [3:0]  seed_b, q_b;
    logic        valid_b, lerr_b;
`ifdef LFSR_PERIOD_CNT_EN
    logic [31:0] pcnt_a;
    logic        pwrap_a;
    logic [3:0]  pcnt_b;
    logic        pwrap_b;
`endif

    lfsr_prng dut_a (
        .clk       (clk),
        .rst       (rst_a),
        .en        (en_a),
        .mode      (mode_a),
        .load      (load_a),
        .seed_in   (seed_a),
        .out_valid (valid_a),
        .out_ready (ready_a),
        .q         (q_a),
        .lock_err  (lerr_a)
`ifdef LFSR_PERIOD_CNT_EN
        ,
        .period_cnt  (pcnt_a),
        .period_wrap (pwrap_a)
`endif
    );

    lfsr_prng #(
        .WIDTH (4),
        .TAPS  (64'h3),
        .SEED  (64'h1)
    ) dut_b (
        .clk       (clk),
        .rst       (rst_b),
        .en        (en_b),
        .mode      (mode_b),
        .load      (load_b),
        .seed_in   (seed_b),
        .out_valid (valid_b),
        .out_ready (ready_b),
        .q         (q_b),
        .lock_err  (lerr_b)
`ifdef LFSR_PERIOD_CNT_EN
        ,
        .period_cnt  (pcnt_b),
        .period_wrap (pwrap_b)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
        $display("check %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Hand-derived 4-bit Fibonacci sequence (taps 0,1) starting after state 1.
    logic [3:0] seq_b [15] = '{4'h8, 4'h4, 4'h2, 4'h9, 4'hC, 4'h6, 4'hB, 4'h5,
                               4'hA, 4'hD, 4'hE, 4'hF, 4'h7, 4'h3, 4'h1};

    initial begin
        rst_a = 1'b1; en_a = 1'b0; mode_a = 1'b0; load_a = 1'b0; ready_a = 1'b0; seed_a = '0;
        rst_b = 1'b1; en_b = 1'b0; mode_b = 1'b0; load_b = 1'b0; ready_b = 1'b0; seed_b = '0;

        // Reset state
        step(); step();
        chk("rst_q", 64'(q_a), 64'h1);
        chk("rst_valid", 64'(valid_a), 64'h0);
        chk("rst_lock_err", 64'(lerr_a), 64'h0);

        // First Fibonacci words
        rst_a = 1'b0; en_a = 1'b1; ready_a = 1'b1;
        chk("idle_valid_before_edge", 64'(valid_a), 64'h0);
        step();
        chk("run_valid", 64'(valid_a), 64'h1);
        chk("fib_w0", 64'(q_a), 64'h0000_0001);
        step(); chk("fib_w1", 64'(q_a), 64'h8000_0000);
        step(); chk("fib_w2", 64'(q_a), 64'hC000_0000);
        step(); chk("fib_w3", 64'(q_a), 64'hE000_0000);

        // Load together with accept: load wins, no advance
        load_a = 1'b1; seed_a = 32'h1;
        step();
        chk("load_vs_accept_q", 64'(q_a), 64'h1);
        chk("load_vs_accept_valid", 64'(valid_a), 64'h1);

        // Galois words
        load_a = 1'b0; mode_a = 1'b1;
        step(); chk("gal_w1", 64'(q_a), 64'h8020_0003);
        step(); chk("gal_w2", 64'(q_a), 64'hC030_0002);

        // Back-pressure: word and valid held
        mode_a = 1'b0; ready_a = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_q", 64'(q_a), 64'hC030_0002);
            chk("bp_valid", 64'(valid_a), 64'h1);
        end
        ready_a = 1'b1;
        step(); chk("bp_single_adv", 64'(q_a), 64'hE018_0001);
        ready_a = 1'b0;
        step(); chk("bp_hold_after", 64'(q_a), 64'hE018_0001);

        // en low without accept: stay valid until accept, then IDLE
        en_a = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("en_low_valid", 64'(valid_a), 64'h1);
            chk("en_low_q", 64'(q_a), 64'hE018_0001);
        end
        ready_a = 1'b1;
        step();
        chk("to_idle_valid", 64'(valid_a), 64'h0);
        chk("to_idle_q", 64'(q_a), 64'h700C_0000);
        step();
        chk("idle_hold_valid", 64'(valid_a), 64'h0);
        chk("idle_hold_q", 64'(q_a), 64'h700C_0000);

        // Load a nonzero seed while idle
        ready_a = 1'b0; load_a = 1'b1; seed_a = 32'h1234_5678;
        step();
        chk("load_q", 64'(q_a), 64'h1234_5678);
        chk("load_valid", 64'(valid_a), 64'h0);
        chk("load_lock_err", 64'(lerr_a), 64'h0);
        load_a = 1'b0; en_a = 1'b1; ready_a = 1'b1;
        step();
        chk("load_run_valid", 64'(valid_a), 64'h1);
        chk("load_run_q", 64'(q_a), 64'h1234_5678);
        step(); chk("load_adv", 64'(q_a), 64'h891A_2B3C);

        // Zero load: recover to SEED with one-cycle lock_err
        ready_a = 1'b0; load_a = 1'b1; seed_a = 32'h0;
        step();
        chk("zero_load_q", 64'(q_a), 64'h1);
        chk("zero_load_lock_err", 64'(lerr_a), 64'h1);
        load_a = 1'b0;
        step();
        chk("lock_err_clear", 64'(lerr_a), 64'h0);
        chk("zero_load_q_hold", 64'(q_a), 64'h1);

        // Mid-stream reset with an unaccepted word
        ready_a = 1'b1;
        step(); chk("pre_rst_q", 64'(q_a), 64'h8000_0000);
        ready_a = 1'b0;
        step();
        rst_a = 1'b1;
        step();
        chk("mid_rst_valid", 64'(valid_a), 64'h0);
        chk("mid_rst_q", 64'(q_a), 64'h1);
        chk("mid_rst_lock_err", 64'(lerr_a), 64'h0);
        rst_a = 1'b0; en_a = 1'b0;
        step();
        chk("post_rst_idle", 64'(valid_a), 64'h0);

        // 4-bit full period
        rst_b = 1'b0; en_b = 1'b1; ready_b = 1'b1;
        step();
        chk("w4_valid", 64'(valid_b), 64'h1);
        chk("w4_q0", 64'(q_b), 64'h1);
`ifdef LFSR_PERIOD_CNT_EN
        chk("w4_cnt0", 64'(pcnt_b), 64'h0);
`endif
        for (int i = 0; i < 15; i++) begin
            step();
            chk("w4_seq", 64'(q_b), 64'(seq_b[i]));
`ifdef LFSR_PERIOD_CNT_EN
            chk("w4_cnt", 64'(pcnt_b), (i < 14) ? 64'(i + 1) : 64'h0);
            chk("w4_wrap", 64'(pwrap_b), (i == 14) ? 64'h1 : 64'h0);
`endif
        end
        ready_b = 1'b0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/lfsr_prng.md
Name: lfsr_prng

Overview:
Parametrised pseudo-random generator; successor to the fixed 32-bit LFSR.
- Configurable width, tap mask and seed.
- Run-time Fibonacci/Galois mode select and seed load.
- Zero lock-up recovery.
- Valid/ready output stream, so consumers (test-pattern generators, scramblers) can back-pressure it.

Parameters:
- WIDTH, 32, state/output width; legal range 4..64.
- TAPS, 32'h8020_0003, tap mask of width WIDTH; bit i set = state bit i is a tap. The default selects bits 31, 21, 1, 0.
- SEED, 1, reset and recovery state, width WIDTH. SEED = 0 is an elaboration error ($error).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- en  in  1  generator enable
- mode  in  1  0 = Fibonacci, 1 = Galois; sampled on each advance
- load  in  1  load seed_in into the state
- seed_in  in  WIDTH  seed value for load
- out_valid  out  1  q holds a word for the consumer
- out_ready  in  1  consumer accepts q
- q  out  WIDTH  current pseudo-random word (the state register)
- lock_err  out  1  one-cycle pulse: an all-zero state was replaced by SEED

Behaviour:
- Clock and reset: single clock domain; all registers update on posedge clk only. Reset is synchronous and active-high.
- Reset values: state = SEED, FSM = IDLE, out_valid = 0, lock_err = 0. While rst = 1, q = SEED.
- Accept: accept = out_valid & out_ready.
- Advance: on accept, state <= next(state) on the following edge; the new q is visible 1 cycle after the accepting edge.
- Fibonacci next(s):
  - fb = XOR over all bits i where TAPS[i] = 1 of s[i].
  - next = {fb, s[WIDTH-1:1]}.
- Galois next(s): next = (s >> 1) ^ ({WIDTH{s[0]}} & TAPS).
- FSM IDLE:
  - out_valid = 0; state holds.
  - en = 1 -> RUN.
- FSM RUN:
  - out_valid = 1.
  - Once asserted, out_valid and q stay stable until accept (load excepted).
  - accept with en = 1 -> stay in RUN and advance.
  - accept with en = 0 -> advance, then go to IDLE.
  - en = 0 without accept -> remain in RUN until accept.
- Load:
  - load = 1: state <= seed_in on the next edge.
  - Load has priority over advance in the same cycle; the pending accept is consumed, with no advance.
  - FSM state and out_valid are unaffected.
  - Load is the only permitted change of q while out_valid = 1 and out_ready = 0.
- Zero lock-up:
  - If a load would write 0, or next(state) evaluates to 0, state <= SEED instead.
  - lock_err = 1 for exactly the cycle after that edge.
- Simultaneous rst with load/en/accept: reset wins.
- Reset mid-stream: out_valid drops on the next edge; the unaccepted word is discarded.
- Widths: all arithmetic is mod 2^WIDTH; TAPS and SEED are truncated/extended to WIDTH.

Optional Feature:
Macro LFSR_PERIOD_CNT_EN.
- Defined:
  - Adds output period_cnt [WIDTH-1:0]: count of advances since the last reset or load, wrapping at 2^WIDTH. Cleared to 0 by reset, by load, and by lock-up recovery.
  - Adds output period_wrap (1 bit): one-cycle pulse when the state returns to the last loaded seed (SEED after reset). period_cnt is cleared on the same edge.
- Not defined: neither port exists; no counter logic is synthesised.

Test Plan:
- Reset/first words (defaults, Fibonacci, out_ready = 1): rst 2 cycles, then en = 1 -> q = 0x0000_0001, 0x8000_0000, 0xC000_0000, 0xE000_0000 on consecutive accepts; out_valid first high 1 cycle after en.
- Galois mode (mode = 1, defaults, out_ready = 1): q = 0x0000_0001, 0x8020_0003, 0xC030_0002.
- Back-pressure: out_ready = 0 for 5 cycles mid-run -> q and out_valid stable; out_ready = 1 -> q advances exactly once per accepting cycle. Also: en = 0 without accept -> out_valid held high until accept, then IDLE.
- Load and lock-up:
  - load with seed_in = 0x1234_5678 -> q = 0x1234_5678 next cycle.
  - load with seed_in = 0 -> q = 0x0000_0001 and a 1-cycle lock_err pulse.
  - load and accept in the same cycle -> load value wins, no advance.
- Small width (WIDTH = 4, TAPS = 4'b0011, SEED = 1, Fibonacci): 15 accepts visit all nonzero states and return to 1. With LFSR_PERIOD_CNT_EN: period_wrap pulses when q returns to 1; period_cnt goes 0..14 then clears to 0 on that same edge.
- Mid-stream reset (rst while out_valid = 1, out_ready = 0): next cycle out_valid = 0, q = SEED, FSM = IDLE, lock_err = 0.
